load_unit: RTL and testbench

Load-side memory access unit for the 64-bit RISC-V multicycle datapath; the read-direction counterpart of the store merge path. It accepts a load request from the control FSM, issues one read to data memory, waits a fixed memory latency, then extracts the doubleword, word, halfword or byte from the low bits of the returned memory word and sign- or zero-extends it to 64 bits for register write-back. It sits between the control unit / ALU address output and the register-file write-data mux.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/load_extend.sv | 38 +++
 rtl/load_unit.sv | 96 +++++++++
 tb/tb_load_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Purpose  : Shared definitions for the load and store memory access paths.
//             Holds the access size encoding (sel[1:0]) and the load FSM
//             state type.
//  Revision : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    // Access size encoding on sel[1:0]; the store merge path uses these too.
    localparam logic [1:0] SZ_WORD   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_BYTE   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    // Load FSM states.
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_READ = 2'd1,
        LD_WAIT = 2'd2,
        LD_DONE = 2'd3
    } load_state_t;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational field extraction and extension for loads.
//             Takes the low doubleword/word/halfword/byte of the memory
//             word and sign- or zero-extends it to 64 bits.
//  Ports    : mem_data [63:0] in   raw memory read data
//             sel      [2:0]  in   [1:0] size, [2] 1 = zero-extend
//             ext      [63:0] out  extended result
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
    import mem_access_pkg::*;
(
    input  logic [63:0] mem_data,
    input  logic [2:0]  sel,
    output logic [63:0] ext
);

    logic w_sign;

    // Sign mode replicates the field MSB; zero mode fills with zeros.
    assign w_sign = ~sel[2];

    always_comb begin
        ext = mem_data;
        case (sel[1:0])
            SZ_WORD:   ext = {{32{w_sign & mem_data[31]}}, mem_data[31:0]};
            SZ_HALF:   ext = {{48{w_sign & mem_data[15]}}, mem_data[15:0]};
            SZ_BYTE:   ext = {{56{w_sign & mem_data[7]}},  mem_data[7:0]};
            // A doubleword fills the register, so the extension bit is moot.
            SZ_DOUBLE: ext = mem_data;
            default:   ext = mem_data;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Load-side memory access unit. Accepts a load request, issues
//             one read strobe, waits MEM_LATENCY cycles, then registers the
//             extracted and extended result for register write-back.
//  Ports    : clk, rst_n            clock, async active-low reset
//             start                 load request (IDLE/DONE only)
//             addr [63:0], sel[2:0] request address and size/extension
//             MemData [63:0]        memory read data
//             mem_rd, mem_addr      read strobe and held read address
//             data_out [63:0]       extended load result (held)
//             done, busy            completion pulse, non-IDLE flag
//  Revision : 1.0  initial release
// ============================================================================
module load_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] addr,
    input  logic [2:0]  sel,
    input  logic [63:0] MemData,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    output logic [63:0] data_out,
    output logic        done,
    output logic        busy
);

    // WAIT spans MEM_LATENCY cycles, so the count starts one below it.
    localparam logic [3:0] c_wait_init = 4'(MEM_LATENCY - 1);

    load_state_t r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_sel;
    logic [63:0] w_ext;

    load_extend u_load_extend (
        .mem_data (MemData),
        .sel      (r_sel),
        .ext      (w_ext)
    );

    // All outputs are registered alongside the state so none depends
    // combinationally on the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LD_IDLE;
            r_cnt    <= 4'd0;
            r_sel    <= 3'd0;
            mem_rd   <= 1'b0;
            mem_addr <= 64'd0;
            data_out <= 64'd0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                // DONE accepts directly so back-to-back loads skip IDLE.
                LD_IDLE, LD_DONE: begin
                    if (start) begin
                        mem_addr <= addr;
                        r_sel    <= sel;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= LD_READ;
                    end else begin
                        busy     <= 1'b0;
                        r_state  <= LD_IDLE;
                    end
                end
                LD_READ: begin
                    r_cnt   <= c_wait_init;
                    r_state <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        data_out <= w_ext;
                        done     <= 1'b1;
                        r_state  <= LD_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

endmodule : load_unit
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Directed self-checking bench for load_unit. Two instances with
//             MEM_LATENCY 1 and 4 share clock, reset and data inputs; each
//             has its own start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;

    logic        clk;
    logic        rst_n;
    logic        start1, start4;
    logic [63:0] addr;
    logic [2:0]  sel;
    logic [63:0] MemData;

    logic        mem_rd1, done1, busy1;
    logic [63:0] mem_addr1, data_out1;
    logic        mem_rd4, done4, busy4;
    logic [63:0] mem_addr4, data_out4;

    int n_checks;
    int n_fail;

    load_unit #(.MEM_LATENCY(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .addr     (addr),
        .sel      (sel),
        .MemData  (MemData),
        .mem_rd   (mem_rd1),
        .mem_addr (mem_addr1),
        .data_out (data_out1),
        .done     (done1),
        .busy     (busy1)
    );

    load_unit #(.MEM_LATENCY(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .addr     (addr),
        .sel      (sel),
        .MemData  (MemData),
        .mem_rd   (mem_rd4),
        .mem_addr (mem_addr4),
        .data_out (data_out4),
        .done     (done4),
        .busy     (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one load on the latency-1 or latency-4 instance and check strobe
    // timing, done latency (in edges after the accept edge) and the result.
    task automatic run_load(input int lat, input logic [2:0] s, input logic [63:0] a,
                            input logic [63:0] md, input logic [63:0] exp, input string tag);
        int  edges;
        bit  found;
        logic rd, dn;
        logic [63:0] dout, maddr;
        sel = s; addr = a; MemData = md;
        if (lat == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        rd    = (lat == 1) ? mem_rd1   : mem_rd4;
        maddr = (lat == 1) ? mem_addr1 : mem_addr4;
        check({tag, "_rd_hi"}, {63'd0, rd}, 64'd1);
        check({tag, "_addr"}, maddr, a);
        edges = 0;
        found = 1'b0;
        while (!found && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            rd = (lat == 1) ? mem_rd1 : mem_rd4;
            dn = (lat == 1) ? done1   : done4;
            if (edges == 1) check({tag, "_rd_lo"}, {63'd0, rd}, 64'd0);
            if (dn) found = 1'b1;
        end
        if (!found) check({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            dout = (lat == 1) ? data_out1 : data_out4;
            check({tag, "_lat"}, 64'(edges), 64'(lat + 1));
            check({tag, "_data"}, dout, exp);
        end
        @(posedge clk); #1;
        dn = (lat == 1) ? done1 : done4;
        check({tag, "_done_pulse"}, {63'd0, dn}, 64'd0);
    endtask

    initial begin
        int k;
        int dones;
        bit found;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
        addr = 64'd0; sel = 3'd0; MemData = 64'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_busy",  {63'd0, busy1}, 64'd0);
        check("rst_done",  {63'd0, done1}, 64'd0);
        check("rst_rd",    {63'd0, mem_rd1}, 64'd0);
        check("rst_data",  data_out1, 64'd0);
        check("rst_addr",  mem_addr1, 64'd0);
        check("rst_busy4", {63'd0, busy4}, 64'd0);

        // Extraction patterns on the latency-1 instance
        run_load(1, 3'b010, 64'h0000_0000_0000_1000, 64'h1234_5678_9ABC_DE80, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        check("idle_busy", {63'd0, busy1}, 64'd0);
        check("idle_addr_held", mem_addr1, 64'h0000_0000_0000_1000);
        run_load(1, 3'b110, 64'h0000_0000_0000_1008, 64'h1234_5678_9ABC_DE80, 64'h0000_0000_0000_0080, "lbu");
        run_load(1, 3'b101, 64'h0000_0000_0000_2000, 64'h0000_0000_8000_F00D, 64'h0000_0000_0000_F00D, "lhu");
        run_load(1, 3'b001, 64'h0000_0000_0000_2002, 64'h0000_0000_8000_F00D, 64'hFFFF_FFFF_FFFF_F00D, "lh");
        run_load(1, 3'b000, 64'h0000_0000_0000_2004, 64'h0000_0000_8000_F00D, 64'hFFFF_FFFF_8000_F00D, "lw");
        run_load(1, 3'b100, 64'h0000_0000_0000_2004, 64'h0000_0000_8000_F00D, 64'h0000_0000_8000_F00D, "lwu");
        run_load(1, 3'b111, 64'h0000_0000_0000_3000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, "ld111");

        // ld with latency 4 while MemData changes every cycle
        sel = 3'b011; addr = 64'h0000_0000_0000_4000; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        MemData = 64'hA5A5_0000_0000_0000;
        found = 1'b0;
        for (k = 1; k <= 12 && !found; k++) begin
            @(posedge clk); #1;
            if (done4) begin
                found = 1'b1;
                check("ld4_lat", 64'(k), 64'd5);
                check("ld4_data", data_out4, 64'hA5A5_0000_0000_0004);
            end
            MemData = 64'hA5A5_0000_0000_0000 | 64'(k);
        end
        if (!found) check("ld4_timeout", 64'd0, 64'd1);
        repeat (2) @(posedge clk); #1;

        // Back-to-back on latency 1: start held high through DONE
        sel = 3'b011; addr = 64'h0000_0000_0000_5000; MemData = 64'h0123_4567_89AB_CDEF;
        start1 = 1'b1;
        @(posedge clk); #1;
        found = 1'b0;
        for (k = 1; k <= 10 && !found; k++) begin
            @(posedge clk); #1;
            if (done1) found = 1'b1;
        end
        if (!found) check("b2b_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        check("b2b_rd_after_done", {63'd0, mem_rd1}, 64'd1);
        check("b2b_busy", {63'd0, busy1}, 64'd1);
        start1 = 1'b0;
        dones = 0;
        for (k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done1) dones++;
        end
        check("b2b_second_done", 64'(dones), 64'd1);

        // start pulses during READ/WAIT are ignored on latency 4
        sel = 3'b000; addr = 64'h0000_0000_0000_6000; MemData = 64'h0000_0000_7FFF_FFFF;
        start4 = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (k = 0; k < 16; k++) begin
            start4 = (k < 5) ? ~start4 : 1'b0;
            @(posedge clk); #1;
            if (done4) dones++;
        end
        start4 = 1'b0;
        check("ignore_one_done", 64'(dones), 64'd1);
        check("ignore_data", data_out4, 64'h0000_0000_7FFF_FFFF);

        // Asynchronous reset in WAIT abandons the load
        sel = 3'b011; addr = 64'h0000_0000_0000_7000; MemData = 64'hDEAD_BEEF_0000_1111;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy4}, 64'd0);
        check("arst_rd",   {63'd0, mem_rd4}, 64'd0);
        check("arst_data", data_out4, 64'd0);
        check("arst_addr", mem_addr4, 64'd0);
        check("arst_data1", data_out1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        check("arst_no_done", 64'(dones), 64'd0);
        run_load(4, 3'b010, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_load_unit
`default_nettype wire
